mem_access_unit: RTL and testbench

- Load/store front end between the core's execute stage and the 1024x32 byte-write-enable block RAM.
- Accepts one RV32I load or store at a time (LB/LH/LW/LBU/LHU/SB/SH/SW):
  - stores: generates RAM byte write enables and lane-replicated write data;
  - loads: waits out the RAM's 1-cycle read latency, then extracts and sign-/zero-extends the result.
- Single outstanding request; valid/ready on the request side, one-cycle response pulse.

---
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store front end for a 1024x32 byte-write-enable RAM.
// Define MISALIGN_TRAP_EN to reject misaligned H/W accesses with resp_err.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        RESP
    } state_t;

    state_t      state, state_n;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        accept;
    logic        is_b, is_h, is_w;
    logic        enc_ok, misal, ok;
    logic [1:0]  off;
    logic [31:0] shifted;
    logic [31:0] ld_data;
    logic        unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign req_ready   = (state == IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign resp_valid  = (state == RESP);
    assign ram_addr    = req_addr[ADDR_W+1:2];

    always_comb begin
        is_b  = (req_funct3[1:0] == 2'b00);
        is_h  = (req_funct3[1:0] == 2'b01);
        is_w  = (req_funct3 == 3'b010);
        if (req_we)
            enc_ok = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
        else
            enc_ok = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);
        misal = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
`ifdef MISALIGN_TRAP_EN
        ok = enc_ok && !misal;
`else
        ok = enc_ok;
`endif
        // Without the trap, misaligned H/W silently align down.
        off = req_addr[1:0];
        if (is_h)
            off = {req_addr[1], 1'b0};
        else if (is_w)
            off = 2'b00;
    end

    always_comb begin
        ram_en = accept && ok;
        ram_we = 4'b0000;
        ram_di = req_wdata;
        if (ram_en && req_we) begin
            unique case (1'b1)
                is_b: begin
                    ram_we = 4'b0001 << off;
                    ram_di = {4{req_wdata[7:0]}};
                end
                is_h: begin
                    ram_we = 4'b0011 << off;
                    ram_di = {2{req_wdata[15:0]}};
                end
                default: begin
                    ram_we = 4'b1111;
                    ram_di = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        shifted = ram_dout >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_data = {24'h0, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_n = (ok && !req_we) ? LOAD_WAIT : RESP;
            end
            LOAD_WAIT: state_n = RESP;
            RESP:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Response fields change only when entering RESP so they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                f3_q  <= req_funct3;
                off_q <= off;
                if (!ok || req_we) begin
                    resp_rdata <= 32'h0;
                    resp_err   <= !ok;
                end
            end
            if (state == LOAD_WAIT) begin
                resp_rdata <= ld_data;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector bench for mem_access_unit
// with a behavioural 1024x32 byte-write RAM and 1-cycle read latency.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout;

    logic [31:0] mem [1024];

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b])
                    mem[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
            ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        en;
        logic [3:0]  we4;
        logic [31:0] di;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic en, input logic [3:0] we4,
                                input logic [31:0] di, input logic [31:0] rd,
                                input logic err, input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.en = en; v.we4 = we4; v.di = di; v.rd = rd;
        v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic run(input vec_t v, input string nm);
        int n;
        logic stray;
        logic [31:0] a;
        a = v.addr;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " ready"}, {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wd;
        #1;
        chk({nm, " ram_en"}, {31'h0, ram_en}, {31'h0, v.en});
        chk({nm, " ram_we"}, {28'h0, ram_we}, {28'h0, v.we4});
        if (v.en) chk({nm, " ram_addr"}, {22'h0, ram_addr}, {22'h0, a[11:2]});
        if (v.en && v.we) chk({nm, " ram_di"}, ram_di, v.di);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        stray = 1'b0;
        do begin
            @(negedge clk);
            n++;
            stray = stray | ram_en;
        end while (!resp_valid && n < 6);
        if (!resp_valid) n = 99;
        chk({nm, " latency"}, n, v.lat);
        chk({nm, " stray ram_en"}, {31'h0, stray}, 32'h0);
        chk({nm, " rdata"}, resp_rdata, v.rd);
        chk({nm, " err"}, {31'h0, resp_err}, {31'h0, v.err});
        @(negedge clk);
        chk({nm, " pulse"}, {31'h0, resp_valid}, 32'h0);
        chk({nm, " hold"}, resp_rdata, v.rd);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'hCAFEF00D;
        mem[4] = 32'h8899AABB;
        mem[8] = 32'h01020304;

        //       we  f3    addr         wdata         en we4     di            rdata         err lat
        vt[0]  = mk(0, 3'b000, 32'h11, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFFFFAA, 0, 2);
        vt[1]  = mk(0, 3'b100, 32'h11, 32'h0,        1, 4'b0000, 32'h0,        32'h000000AA, 0, 2);
        vt[2]  = mk(0, 3'b101, 32'h12, 32'h0,        1, 4'b0000, 32'h0,        32'h00008899, 0, 2);
        vt[3]  = mk(0, 3'b001, 32'h10, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFFAABB, 0, 2);
        vt[4]  = mk(0, 3'b010, 32'h10, 32'h0,        1, 4'b0000, 32'h0,        32'h8899AABB, 0, 2);
        vt[5]  = mk(1, 3'b000, 32'h22, 32'h5A,       1, 4'b0100, 32'h5A5A5A5A, 32'h0,        0, 1);
        vt[6]  = mk(0, 3'b010, 32'h20, 32'h0,        1, 4'b0000, 32'h0,        32'h015A0304, 0, 2);
        vt[7]  = mk(1, 3'b001, 32'h06, 32'hBEEF,     1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 1);
        vt[8]  = mk(0, 3'b001, 32'h06, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFFBEEF, 0, 2);
        vt[9]  = mk(0, 3'b111, 32'h10, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 1);
        vt[10] = mk(1, 3'b100, 32'h10, 32'h77,       0, 4'b0000, 32'h0,        32'h0,        1, 1);
        vt[11] = mk(0, 3'b010, 32'h1004, 32'h0,      1, 4'b0000, 32'h0,        32'hBEEFF00D, 0, 2);
        vt[12] = mk(0, 3'b010, 32'h04, 32'h0,        1, 4'b0000, 32'h0,        32'hBEEFF00D, 0, 2);
        vt[13] = mk(1, 3'b010, 32'h30, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 1);
        vt[14] = mk(0, 3'b100, 32'h33, 32'h0,        1, 4'b0000, 32'h0,        32'h000000DE, 0, 2);
`ifdef MISALIGN_TRAP_EN
        vt[15] = mk(0, 3'b010, 32'h03, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 1);
        vt[16] = mk(0, 3'b101, 32'h13, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 1);
`else
        vt[15] = mk(0, 3'b010, 32'h03, 32'h0,        1, 4'b0000, 32'h0,        32'h11223344, 0, 2);
        vt[16] = mk(0, 3'b101, 32'h13, 32'h0,        1, 4'b0000, 32'h0,        32'h00008899, 0, 2);
`endif

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst rdata", resp_rdata, 32'h0);
        chk("rst err", {31'h0, resp_err}, 32'h0);
        chk("rst ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst ram_we", {28'h0, ram_we}, 32'h0);
        chk("rst ready", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        #1;
        chk("post-rst ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 17; i++)
            run(vt[i], $sformatf("v%0d", i));

        // Back-to-back SW then LW held valid across the busy cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h12345678;
        #1;
        chk("b2b sw ready", {31'h0, req_ready}, 32'h1);
        chk("b2b sw ram_we", {28'h0, ram_we}, 32'hF);
        @(posedge clk);
        #1;
        req_we = 1'b0;
        @(negedge clk);
        chk("b2b busy ready", {31'h0, req_ready}, 32'h0);
        chk("b2b sw resp", {31'h0, resp_valid}, 32'h1);
        chk("b2b busy ram_en", {31'h0, ram_en}, 32'h0);
        @(negedge clk);
        chk("b2b lw ready", {31'h0, req_ready}, 32'h1);
        chk("b2b lw ram_en", {31'h0, ram_en}, 32'h1);
        chk("b2b lw ram_we", {28'h0, ram_we}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b lw wait", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        chk("b2b lw resp", {31'h0, resp_valid}, 32'h1);
        chk("b2b lw rdata", resp_rdata, 32'h12345678);

        // Reset while a load is in LOAD_WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstlw resp", {31'h0, resp_valid}, 32'h0);
        chk("rstlw ready in rst", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rstlw ready", {31'h0, req_ready}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstlw quiet%0d", k), {31'h0, resp_valid}, 32'h0);
        end
        chk("rstlw idle", {31'h0, req_ready}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
